// File: rtl/pipe_stage_reg.sv
// Two-entry (main + skid) pipeline stage register with kill, flush and stall.
// Optional performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               ZERO_BUBBLE = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_kill,
  input  logic             flush,
  input  logic             stall,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      bubble_cycles
`endif
);

  // Encoding is {main valid, skid valid}; the valid bits are the whole control state.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } stageState_e;

  stageState_e      state_reg;
  stageState_e      state_next;
  logic [WIDTH-1:0] mainData_reg;
  logic [WIDTH-1:0] skidData_reg;

  logic mainValid;
  logic skidValid;
  logic accept;
  logic storeAccept;
  logic fire;
  logic loadMain;
  logic loadSkid;
  logic mainFromSkid;

  assign mainValid   = state_reg[1];
  assign skidValid   = state_reg[0];
  assign in_ready    = ~skidValid;
  assign out_valid   = mainValid;
  assign accept      = in_valid & in_ready & ~flush;
  assign storeAccept = accept & ~in_kill;
  assign fire        = mainValid & out_ready & ~stall;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    loadMain     = 1'b0;
    loadSkid     = 1'b0;
    mainFromSkid = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (storeAccept) begin
            state_next = ONE;
            loadMain   = 1'b1;
          end
        end
        ONE: begin
          if (fire && storeAccept) begin
            loadMain = 1'b1;
          end else if (fire) begin
            state_next = EMPTY;
          end else if (storeAccept) begin
            state_next = FULL;
            loadSkid   = 1'b1;
          end
        end
        FULL: begin
          if (fire) begin
            state_next   = ONE;
            mainFromSkid = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // Data only moves on a stored accept or a skid-to-main transfer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mainData_reg <= RESET_VALUE;
      skidData_reg <= RESET_VALUE;
    end else begin
      if (loadMain) begin
        mainData_reg <= in_data;
      end else if (mainFromSkid) begin
        mainData_reg <= skidData_reg;
      end
      if (loadSkid) begin
        skidData_reg <= in_data;
      end
    end
  end

  generate
    if (ZERO_BUBBLE != 0) begin : gZeroBubble
      assign out_data = mainValid ? mainData_reg : RESET_VALUE;
    end else begin : gHoldData
      assign out_data = mainData_reg;
    end
  endgenerate

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stallCycles_reg;
  logic [31:0] bubbleCycles_reg;

  // Saturating counters; flush does not touch them, only reset does.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stallCycles_reg  <= '0;
      bubbleCycles_reg <= '0;
    end else begin
      if (mainValid && !fire && (stallCycles_reg != 32'hFFFF_FFFF)) begin
        stallCycles_reg <= stallCycles_reg + 32'd1;
      end
      if (!mainValid && (bubbleCycles_reg != 32'hFFFF_FFFF)) begin
        bubbleCycles_reg <= bubbleCycles_reg + 32'd1;
      end
    end
  end

  assign stall_cycles  = stallCycles_reg;
  assign bubble_cycles = bubbleCycles_reg;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus random traffic
// checked against a two-deep FIFO reference model.
module tb_pipe_stage_reg;

  localparam logic [31:0] RV = 32'hDEAD_BEEF;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_kill;
  logic        flush;
  logic        stall;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] bubble_cycles;
`endif

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(
    .WIDTH(32),
    .RESET_VALUE(RV),
    .ZERO_BUBBLE(1)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_kill(in_kill),
    .flush(flush),
    .stall(stall),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .bubble_cycles(bubble_cycles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: a FIFO of capacity two; ready means "fewer than two held".
  logic [31:0] mq[$];
  logic [31:0] mStall;
  logic [31:0] mBubble;

  always @(posedge clock or negedge reset_n) begin : model
    int  sz;
    bit  mFire;
    bit  mAcc;
    if (!reset_n) begin
      mq.delete();
      mStall  = 0;
      mBubble = 0;
    end else begin
      sz    = mq.size();
      mFire = (sz > 0) && out_ready && !stall;
      mAcc  = in_valid && (sz < 2) && !flush && !in_kill;
      if (sz > 0 && !mFire && mStall != 32'hFFFF_FFFF) mStall = mStall + 1;
      if (sz == 0 && mBubble != 32'hFFFF_FFFF) mBubble = mBubble + 1;
      if (flush) begin
        mq.delete();
      end else begin
        if (mFire) void'(mq.pop_front());
        if (mAcc) mq.push_back(in_data);
      end
    end
  end

  task automatic go_idle();
    in_valid = 0; in_kill = 0; stall = 0; out_ready = 0; flush = 1;
    @(negedge clock);
    flush = 0;
  endtask

  task automatic test_reset();
    reset_n = 0; in_valid = 0; in_data = 0; in_kill = 0; flush = 0; stall = 0; out_ready = 0;
    repeat (2) @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_data !== RV) begin errors++; $display("FAIL reset_out_data: got %h expected %h", out_data, RV); end
`ifdef PIPE_STAGE_PERF_EN
    checks++; if (stall_cycles !== 0 || bubble_cycles !== 0) begin errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cycles, bubble_cycles); end
`endif
    reset_n = 1;
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle: got out_valid %b expected 0", out_valid); end
    $display("reset: done");
  endtask

  task automatic test_first_beat();
    in_valid = 1; in_data = 32'hA5A5_0001; out_ready = 1;
    @(negedge clock);
    in_valid = 0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_out_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== 32'hA5A5_0001) begin errors++; $display("FAIL first_out_data: got %h expected a5a50001", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL first_in_ready: got %b expected 1", in_ready); end
    @(negedge clock);
    $display("first_beat: out=%h", 32'hA5A5_0001);
  endtask

  task automatic test_skid_fill();
    go_idle();
    in_valid = 1; in_data = 1;
    @(negedge clock); in_data = 2;
    @(negedge clock); in_data = 3;
    @(negedge clock);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL skid_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_data !== 32'd1) begin errors++; $display("FAIL skid_head: got %h expected 1", out_data); end
    out_ready = 1;
    @(negedge clock);
    checks++; if (out_data !== 32'd2 || out_valid !== 1'b1) begin errors++; $display("FAIL skid_second: got %h/%b expected 2/1", out_data, out_valid); end
    @(negedge clock);
    in_valid = 0;
    checks++; if (out_data !== 32'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL skid_third: got %h/%b expected 3/1", out_data, out_valid); end
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL skid_drained: got %b expected 0", out_valid); end
    $display("skid_fill: beats 1,2,3 drained");
  endtask

  task automatic test_stall_full();
    logic [31:0] s0;
    go_idle();
    in_valid = 1; in_data = 11;
    @(negedge clock); in_data = 12;
    @(negedge clock);
    in_valid = 0; stall = 1; out_ready = 1;
`ifdef PIPE_STAGE_PERF_EN
    s0 = stall_cycles;
`else
    s0 = 0;
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++; if (out_data !== 32'd11 || out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d]: got %h/%b expected 11/1", i, out_data, out_valid); end
    end
`ifdef PIPE_STAGE_PERF_EN
    checks++; if (stall_cycles !== s0 + 32'd3) begin errors++; $display("FAIL stall_count: got %0d expected %0d", stall_cycles, s0 + 32'd3); end
`endif
    stall = 0;
    @(negedge clock);
    checks++; if (out_data !== 32'd12) begin errors++; $display("FAIL stall_release: got %h expected 12", out_data); end
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drained: got %b expected 0", out_valid); end
    $display("stall_full: held for 3 cycles from %0d", s0);
  endtask

  task automatic test_flush();
    go_idle();
    in_valid = 1; in_data = 21;
    @(negedge clock); in_data = 22;
    @(negedge clock);
    flush = 1; in_data = 32'h77;
    @(negedge clock);
    flush = 0; in_valid = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_data !== RV) begin errors++; $display("FAIL flush_out_data: got %h expected %h", out_data, RV); end
    out_ready = 1;
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_leak: got %b expected 0", out_valid); end
    $display("flush: full stage emptied");
  endtask

  task automatic test_kill();
    go_idle();
    in_valid = 1; in_kill = 1; in_data = 32'h55; out_ready = 1;
    @(negedge clock);
    in_valid = 0; in_kill = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL kill_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== RV) begin errors++; $display("FAIL kill_out_data: got %h expected %h", out_data, RV); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL kill_in_ready: got %b expected 1", in_ready); end
    $display("kill: beat 55 squashed");
  endtask

  task automatic test_async_reset();
    go_idle();
    in_valid = 1; in_data = 31;
    @(negedge clock); in_data = 32;
    @(negedge clock);
    in_valid = 0; out_ready = 1;
    @(posedge clock);
    #2 reset_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== RV) begin errors++; $display("FAIL areset_out_data: got %h expected %h", out_data, RV); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready: got %b expected 1", in_ready); end
    @(negedge clock);
    reset_n = 1;
    in_valid = 1; in_data = 41;
    @(negedge clock);
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd41) begin errors++; $display("FAIL areset_first: got %h/%b expected 41/1", out_data, out_valid); end
    @(negedge clock);
    $display("async_reset: entries lost, restart ok");
  endtask

  task automatic test_random();
    logic [31:0] expData;
    int          localErr;
    localErr = errors;
    for (int i = 0; i < 3000; i++) begin
      expData = (mq.size() > 0) ? mq[0] : RV;
      checks++; if (out_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_out_valid[%0d]: got %b expected %b", i, out_valid, mq.size() > 0); end
      checks++; if (in_ready !== (mq.size() < 2)) begin errors++; $display("FAIL rnd_in_ready[%0d]: got %b expected %b", i, in_ready, mq.size() < 2); end
      checks++; if (out_data !== expData) begin errors++; $display("FAIL rnd_out_data[%0d]: got %h expected %h", i, out_data, expData); end
`ifdef PIPE_STAGE_PERF_EN
      checks++; if (stall_cycles !== mStall || bubble_cycles !== mBubble) begin errors++; $display("FAIL rnd_counters[%0d]: got %0d/%0d expected %0d/%0d", i, stall_cycles, bubble_cycles, mStall, mBubble); end
`endif
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      stall     = ($urandom_range(0, 6) == 0);
      in_kill   = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_data   = $urandom;
      @(negedge clock);
    end
    in_valid = 0; out_ready = 0; stall = 0; in_kill = 0; flush = 0;
    $display("random: 3000 cycles, %0d new errors", errors - localErr);
  endtask

  initial begin
    test_reset();
    test_first_beat();
    test_skid_fill();
    test_stall_full();
    test_flush();
    test_kill();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
